fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives the instruction-memory request handshake.
- Produces the instruction word, its PC+4 and a valid flag, which IF/ID consumes.
- Honours stall requests from the hazard unit and taken-branch redirects from EX/MEM; buffers one fetched word when a stall collides with a memory acknowledge.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_skid_buffer.sv | 37 +++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline types and defaults for the fetch stage
// Purpose: fetch FSM state enum, reset/NOP defaults and the IF payload struct
//          (instruction word plus its PC+4), also usable by the IF/ID register.
// Ports:   none (package).
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } if_payload_t;

  // Redirect targets are word aligned; the low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// rtl/fetch_stage_skid_buffer.sv - single-entry IF payload holding register
// Purpose: captures one fetched word when a stall collides with a memory ack.
// Ports:   clk, rst_n      clock, async active-low reset
//          i_load, i_data  capture a payload (load wins over clear)
//          i_clear         drop the held payload
//          o_data, o_full  held payload and its occupancy flag
import fetch_stage_pkg::*;

module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  if_payload_t i_data,
  output if_payload_t o_data,
  output logic        o_full
);

  if_payload_t r_data;
  logic        r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage feeding the IF/ID register
// Purpose: owns the PC, drives the imem request handshake, honours stall and
//          branch redirect, and parks one word in a skid buffer when a stall
//          arrives in the same cycle as a memory ack.
// Ports:   clk, rst_n                       clock, async active-low reset
//          stall_i                          hold PC and IF outputs
//          branch_taken_i, branch_target_i  redirect fetch
//          imem_req_o, imem_addr_o          fetch request / address (= pc)
//          imem_ack_i, imem_rdata_i         same-cycle accept and word
//          if_instr_o, if_pcplus4_o, if_valid_o  registered IF outputs
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pcplus4_o,
  output logic        if_valid_o
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  if_payload_t  r_out, w_out_nxt;
  logic         r_valid, w_valid_nxt;

  logic         w_skid_load;
  logic         w_skid_clear;
  logic         w_skid_full;
  if_payload_t  w_skid_data;
  if_payload_t  w_fetched;
  logic [31:0]  w_pcplus4;
  logic [31:0]  w_target;

  assign w_pcplus4 = r_pc + 32'd4;
  assign w_target  = align_word(branch_target_i);
  assign w_fetched = '{instr: imem_rdata_i, pcplus4: w_pcplus4};

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_fetched),
    .o_data  (w_skid_data),
    .o_full  (w_skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_out   <= '{instr: NOP_WORD, pcplus4: 32'h0};
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_out_nxt    = r_out;
    w_valid_nxt  = r_valid;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;

    case (r_state)
      FETCH: begin
        if (branch_taken_i) begin
          // Same-cycle ack is discarded; pcplus4 is left as-is.
          w_pc_nxt        = w_target;
          w_out_nxt.instr = NOP_WORD;
          w_valid_nxt     = 1'b0;
        end else if (stall_i) begin
          if (imem_ack_i) begin
            // IF/ID is frozen, so the accepted word waits in the skid buffer.
            w_skid_load = 1'b1;
            w_pc_nxt    = w_pcplus4;
            w_state_nxt = HELD;
          end
        end else if (imem_ack_i) begin
          w_out_nxt   = w_fetched;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pcplus4;
        end else begin
          w_out_nxt.instr = NOP_WORD;
          w_valid_nxt     = 1'b0;
        end
      end
      HELD: begin
        if (branch_taken_i) begin
          w_skid_clear    = 1'b1;
          w_pc_nxt        = w_target;
          w_out_nxt.instr = NOP_WORD;
          w_valid_nxt     = 1'b0;
          w_state_nxt     = FETCH;
        end else if (!stall_i) begin
          w_out_nxt    = w_skid_data;
          w_valid_nxt  = w_skid_full;
          w_skid_clear = 1'b1;
          w_state_nxt  = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // Gated by rst_n so no request is presented while reset is asserted.
  assign imem_req_o   = (r_state == FETCH) && rst_n;
  assign imem_addr_o  = r_pc;
  assign if_instr_o   = r_out.instr;
  assign if_pcplus4_o = r_out.pcplus4;
  assign if_valid_o   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pcplus4_o;
  logic        if_valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_instr_o      (if_instr_o),
    .if_pcplus4_o    (if_pcplus4_o),
    .if_valid_o      (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"},   if_instr_o,   instr);
    check({tag, ".pcplus4"}, if_pcplus4_o, pc4);
    check({tag, ".valid"},   {31'b0, if_valid_o}, {31'b0, valid});
  endtask

  task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"},  {31'b0, imem_req_o}, {31'b0, req});
    check({tag, ".addr"}, imem_addr_o, addr);
  endtask

  task automatic drive(input logic stall, input logic br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] data);
    stall_i         = stall;
    branch_taken_i  = br;
    branch_target_i = tgt;
    imem_ack_i      = ack;
    imem_rdata_i    = data;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    #3;
    check_out("rst", 32'h0, 32'h0, 0);
    check_mem("rst", 0, 32'h0);

    tick();
    rst_n = 1'b1;
    #1;
    check_mem("rel", 1, 32'h0);

    drive(0, 0, 32'h0, 1, 32'h2008_0001);
    tick();
    check_out("f0", 32'h2008_0001, 32'h4, 1);
    check_mem("f0", 1, 32'h4);
    drive(0, 0, 32'h0, 1, 32'h2009_0002);
    tick();
    check_out("f1", 32'h2009_0002, 32'h8, 1);
    check_mem("f1", 1, 32'h8);

    drive(0, 0, 32'h0, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out("bubble", 32'h0, 32'h8, 0);
      check_mem("bubble", 1, 32'h8);
    end

    drive(0, 0, 32'h0, 1, 32'h1111_1111);
    tick();
    check_out("f2", 32'h1111_1111, 32'hC, 1);
    check_mem("f2", 1, 32'hC);

    drive(1, 0, 32'h0, 1, 32'hAABB_CCDD);
    tick();
    check_out("stall_ack", 32'h1111_1111, 32'hC, 1);
    check_mem("stall_ack", 0, 32'h10);
    drive(1, 0, 32'h0, 0, 32'h0);
    tick();
    check_out("held", 32'h1111_1111, 32'hC, 1);
    check_mem("held", 0, 32'h10);
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    check_out("unstall", 32'hAABB_CCDD, 32'h10, 1);
    check_mem("unstall", 1, 32'h10);

    drive(0, 1, 32'h0000_0043, 1, 32'hDEAD_BEEF);
    tick();
    check_out("branch", 32'h0, 32'h10, 0);
    check_mem("branch", 1, 32'h40);

    drive(1, 0, 32'h0, 1, 32'h1234_5678);
    tick();
    check_mem("held2", 0, 32'h44);
    drive(1, 1, 32'h0000_0100, 0, 32'h0);
    tick();
    check_out("br_held", 32'h0, 32'h10, 0);
    check_mem("br_held", 1, 32'h100);
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    check_out("no_skid", 32'h0, 32'h10, 0);

    drive(0, 1, 32'hFFFF_FFFE, 0, 32'h0);
    tick();
    check_mem("br_top", 1, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 1, 32'h0000_0055);
    tick();
    check_out("wrap", 32'h0000_0055, 32'h0, 1);
    check_mem("wrap", 1, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h0000_0066);
    tick();
    check_out("f3", 32'h0000_0066, 32'h4, 1);
    drive(1, 0, 32'h0, 1, 32'h9999_9999);
    tick();
    check_mem("held3", 0, 32'h8);

    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 32'h0, 0);
    check_mem("async_rst", 0, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check_mem("rel2", 1, 32'h0);
    tick();
    check_out("rel2", 32'h0, 32'h0, 0);
    check_mem("rel2b", 1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
